// File: rtl/host_req_arb_pkg.sv
// Shared types, default parameters and the round-robin pick helper for
// the host request arbiter.
package host_arb_pkg;

  localparam int unsigned NumHostsDefault       = 2;
  localparam int unsigned MaxOutstandingDefault = 2;
  localparam int unsigned DataWidthDefault      = 32;
  localparam int unsigned AddrWidthDefault      = 32;
  localparam int unsigned IdWDefault =
      ($clog2(NumHostsDefault) > 1) ? $clog2(NumHostsDefault) : 1;

  typedef logic [IdWDefault-1:0] host_id_t;

  // The pick helper works on a fixed 32-host window so that one function
  // serves every NumHosts instantiation; callers zero-extend into it.
  localparam int unsigned RrMaxHosts = 32;
  localparam int unsigned RrIdW      = 5;

  typedef logic [RrMaxHosts-1:0] rr_req_t;
  typedef logic [RrIdW-1:0]      rr_idx_t;

  typedef struct packed {
    logic    vld;
    rr_idx_t idx;
  } rr_pick_t;

  typedef enum logic {
    ArbIdle   = 1'b0,
    ArbLocked = 1'b1
  } arb_state_e;

  // First requesting host at or after ptr, wrapping modulo n.
  function automatic rr_pick_t rr_pick(input rr_req_t req, input rr_idx_t ptr,
                                       input int unsigned n);
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned k = 0; k < RrMaxHosts; k++) begin
      cand = (32'(ptr) + k) % n;
      if (k < n && !res.vld && req[rr_idx_t'(cand)]) begin
        res.vld = 1'b1;
        res.idx = rr_idx_t'(cand);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/host_req_arb_if.sv
// Requester-side and adapter-side bus of the host request arbiter.
// The slave modport is the arbiter's view; master is the environment's.
interface host_req_arb_if
  import host_arb_pkg::*;
#(
  parameter int unsigned NumHosts  = NumHostsDefault,
  parameter int unsigned DataWidth = DataWidthDefault,
  parameter int unsigned AddrWidth = AddrWidthDefault
);
  localparam int unsigned BeW = DataWidth / 8;

  // requester side
  logic [NumHosts-1:0]           h_req_i;
  logic [NumHosts-1:0]           h_gnt_o;
  logic [NumHosts*AddrWidth-1:0] h_addr_i;
  logic [NumHosts-1:0]           h_we_i;
  logic [NumHosts*DataWidth-1:0] h_wdata_i;
  logic [NumHosts*BeW-1:0]       h_be_i;
  logic [NumHosts-1:0]           h_valid_o;
  logic [DataWidth-1:0]          h_rdata_o;
  logic                          h_err_o;

  // adapter side
  logic                 req_o;
  logic                 gnt_i;
  logic [AddrWidth-1:0] addr_o;
  logic                 we_o;
  logic [DataWidth-1:0] wdata_o;
  logic [BeW-1:0]       be_o;
  logic                 valid_i;
  logic [DataWidth-1:0] rdata_i;
  logic                 err_i;

  modport slave (
    input  h_req_i, h_addr_i, h_we_i, h_wdata_i, h_be_i,
    output h_gnt_o, h_valid_o, h_rdata_o, h_err_o,
    output req_o, addr_o, we_o, wdata_o, be_o,
    input  gnt_i, valid_i, rdata_i, err_i
  );

  modport master (
    output h_req_i, h_addr_i, h_we_i, h_wdata_i, h_be_i,
    input  h_gnt_o, h_valid_o, h_rdata_o, h_err_o,
    input  req_o, addr_o, we_o, wdata_o, be_o,
    output gnt_i, valid_i, rdata_i, err_i
  );
endinterface

// File: rtl/host_req_arb_id_fifo.sv
// In-order ID FIFO: remembers which host issued each accepted request so
// responses can be routed back. Push and pop may occur in the same cycle,
// including when full (the pop frees the slot the push uses).
module host_arb_id_fifo
  import host_arb_pkg::*;
#(
  parameter int unsigned Depth = MaxOutstandingDefault,
  parameter int unsigned Width = IdWDefault
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  // One extra pointer bit distinguishes full from empty.
  localparam int unsigned PtrW = $clog2(Depth) + 1;
  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] FullXor = PtrW'(1) << (PtrW - 1);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [IdxW-1:0]  w_wr_idx;
  logic [IdxW-1:0]  w_rd_idx;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = ((r_wr_ptr ^ r_rd_ptr) == FullXor);
  assign w_pop   = i_pop && !w_empty;
  assign w_push  = i_push && (!w_full || w_pop);

  generate
    if (Depth == 1) begin : g_single
      assign w_wr_idx = '0;
      assign w_rd_idx = '0;
    end else begin : g_multi
      assign w_wr_idx = r_wr_ptr[IdxW-1:0];
      assign w_rd_idx = r_rd_ptr[IdxW-1:0];
    end
  endgenerate

  // Advance read/write pointers on pop/push.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
    end
  end

  // Storage holds data only, so it is left out of reset.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[w_wr_idx] <= i_data;
  end

  assign o_data  = r_mem[w_rd_idx];
  assign o_full  = w_full;
  assign o_empty = w_empty;
endmodule

// File: rtl/host_req_arb.sv
// Round-robin arbiter sharing the single req/gnt port of the TL-UL host
// adapter between several requesters. Accepted requester IDs are queued in
// order so responses are routed back to the issuing host. Supports up to
// 32 hosts (width of the shared pick helper).
module host_req_arb
  import host_arb_pkg::*;
#(
  parameter int unsigned NumHosts       = NumHostsDefault,
  parameter int unsigned MaxOutstanding = MaxOutstandingDefault,
  parameter int unsigned DataWidth      = DataWidthDefault,
  parameter int unsigned AddrWidth      = AddrWidthDefault
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  host_req_arb_if.slave   bus,
  output logic            unexp_rsp_o
);
  localparam int unsigned BeW = DataWidth / 8;
  localparam int unsigned IdW = ($clog2(NumHosts) > 1) ? $clog2(NumHosts) : 1;
  localparam logic [NumHosts-1:0] OneHot0 = NumHosts'(1);

  arb_state_e     r_state;
  arb_state_e     w_state_nxt;
  logic [IdW-1:0] r_lock_id;
  logic [IdW-1:0] w_lock_id_nxt;
  logic [IdW-1:0] r_rr_ptr;
  logic [IdW-1:0] w_rr_ptr_nxt;
  logic           r_unexp;

  rr_pick_t       w_pick;
  logic           w_win_vld;
  logic [IdW-1:0] w_win_id;
  logic [IdW-1:0] w_ptr_inc;
  logic           w_room;
  logic           w_req;
  logic           w_accept;
  logic           w_pop;
  logic           w_fifo_full;
  logic           w_fifo_empty;
  logic [IdW-1:0] w_head_id;

  assign w_pick = rr_pick(rr_req_t'(bus.h_req_i), rr_idx_t'(r_rr_ptr), NumHosts);

  // Winner: the locked host while locked, otherwise the round-robin pick.
  always_comb begin
    w_win_id  = IdW'(w_pick.idx);
    w_win_vld = w_pick.vld;
    if (r_state == ArbLocked) begin
      w_win_id  = r_lock_id;
      w_win_vld = bus.h_req_i[r_lock_id];
    end
  end

  // A response arriving in the same cycle frees a slot, so a full FIFO
  // does not block a request while it is being drained. Holding rst_ni
  // low also suppresses the request so every output is quiet in reset.
  assign w_pop     = bus.valid_i && !w_fifo_empty;
  assign w_room    = !w_fifo_full || w_pop;
  assign w_req     = w_win_vld && w_room && rst_ni;
  assign w_accept  = w_req && bus.gnt_i;
  assign w_ptr_inc = (w_win_id == IdW'(NumHosts - 1)) ? '0 : w_win_id + 1'b1;

  assign bus.req_o   = w_req;
  assign bus.h_gnt_o = w_accept ? (OneHot0 << w_win_id) : '0;
  assign bus.addr_o  = bus.h_addr_i[w_win_id*AddrWidth +: AddrWidth];
  assign bus.we_o    = bus.h_we_i[w_win_id];
  assign bus.wdata_o = bus.h_wdata_i[w_win_id*DataWidth +: DataWidth];
  assign bus.be_o    = bus.h_be_i[w_win_id*BeW +: BeW];

  assign bus.h_valid_o = w_pop ? (OneHot0 << w_head_id) : '0;
  assign bus.h_rdata_o = bus.rdata_i;
  assign bus.h_err_o   = bus.err_i;
  assign unexp_rsp_o   = r_unexp;

  // Lock FSM and round-robin pointer next-state.
  always_comb begin
    w_state_nxt   = r_state;
    w_lock_id_nxt = r_lock_id;
    w_rr_ptr_nxt  = r_rr_ptr;
    case (r_state)
      ArbIdle: begin
        if (w_accept) begin
          w_rr_ptr_nxt = w_ptr_inc;
        end else if (w_req) begin
          w_state_nxt   = ArbLocked;
          w_lock_id_nxt = w_win_id;
        end
      end
      ArbLocked: begin
        if (w_accept) begin
          w_state_nxt  = ArbIdle;
          w_rr_ptr_nxt = w_ptr_inc;
        end else if (!bus.h_req_i[r_lock_id]) begin
          // locked host withdrew its request: release without a transfer
          w_state_nxt = ArbIdle;
        end
      end
    endcase
  end

  // Lock FSM and round-robin pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ArbIdle;
      r_lock_id <= '0;
      r_rr_ptr  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_id <= w_lock_id_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
    end
  end

  // Sticky flag for a response with no outstanding request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_unexp <= 1'b0;
    end else if (bus.valid_i && w_fifo_empty) begin
      r_unexp <= 1'b1;
    end
  end

  host_arb_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdW)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_push  (w_accept),
    .i_data  (w_win_id),
    .i_pop   (bus.valid_i),
    .o_data  (w_head_id),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );
endmodule

// File: tb/tb_host_req_arb.sv
// Bench for host_req_arb: directed scenarios followed by random traffic,
// all compared against a queue-based reference model of the arbiter.
module tb_host_req_arb;
  import host_arb_pkg::*;

  localparam int NH = 2;
  localparam int MO = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic unexp;

  always #5 clk = ~clk;

  host_req_arb_if #(.NumHosts(NH), .DataWidth(DW), .AddrWidth(AW)) bus ();

  host_req_arb #(
    .NumHosts(NH), .MaxOutstanding(MO), .DataWidth(DW), .AddrWidth(AW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .bus         (bus.slave),
    .unexp_rsp_o (unexp)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int       m_ptr;
  bit       m_locked;
  int       m_lock_id;
  bit       m_unexp;
  host_id_t q[$];

  // host request fields
  logic [AW-1:0] a_addr [NH];
  logic [DW-1:0] a_wdata[NH];
  logic          a_we   [NH];
  logic [BW-1:0] a_be   [NH];

  logic [NH-1:0] last_gnt;
  logic [NH-1:0] obs_gnt;
  logic [NH-1:0] obs_vld;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fifo_count();
    logic [1:0] c;
    c = dut.u_fifo.r_wr_ptr - dut.u_fifo.r_rd_ptr;
    return c;
  endfunction

  task automatic drive_fields();
    for (int h = 0; h < NH; h++) begin
      bus.h_addr_i[h*AW +: AW]  = a_addr[h];
      bus.h_wdata_i[h*DW +: DW] = a_wdata[h];
      bus.h_we_i[h]             = a_we[h];
      bus.h_be_i[h*BW +: BW]    = a_be[h];
    end
  endtask

  task automatic mdl_reset();
    m_ptr = 0;
    m_locked = 1'b0;
    m_lock_id = 0;
    m_unexp = 1'b0;
    q.delete();
  endtask

  // One clock cycle: drive at posedge+1, check at posedge+3, update the
  // model at the edge, check registered state at posedge+1.
  task automatic step(input logic [NH-1:0] req, input bit gnt, input bit vld,
                      input logic [DW-1:0] rd);
    int            win;
    bit            room;
    bit            e_req;
    logic [NH-1:0] e_gnt;
    logic [NH-1:0] e_vld;
    drive_fields();
    bus.h_req_i = req;
    bus.gnt_i   = gnt;
    bus.valid_i = vld;
    bus.rdata_i = rd;
    bus.err_i   = ^rd;
    #2;
    win = -1;
    if (m_locked) begin
      if (req[m_lock_id]) win = m_lock_id;
    end else begin
      for (int k = 0; k < NH; k++) begin
        if (win < 0 && req[(m_ptr + k) % NH]) win = (m_ptr + k) % NH;
      end
    end
    room  = (q.size() < MO) || (vld && q.size() > 0);
    e_req = (win >= 0) && room;
    e_gnt = '0;
    if (e_req && gnt) e_gnt[win] = 1'b1;
    e_vld = '0;
    if (vld && q.size() > 0) e_vld[q[0]] = 1'b1;
    chk("req_o", bus.req_o, e_req);
    chk("h_gnt_o", bus.h_gnt_o, e_gnt);
    chk("h_valid_o", bus.h_valid_o, e_vld);
    chk("unexp_rsp_o", unexp, m_unexp);
    if (e_req) begin
      chk("addr_o", bus.addr_o, a_addr[win]);
      chk("we_o", bus.we_o, a_we[win]);
      chk("wdata_o", bus.wdata_o, a_wdata[win]);
      chk("be_o", bus.be_o, a_be[win]);
    end
    if (vld) begin
      chk("h_rdata_o", bus.h_rdata_o, rd);
      chk("h_err_o", bus.h_err_o, ^rd);
    end
    obs_gnt  = bus.h_gnt_o;
    obs_vld  = bus.h_valid_o;
    last_gnt = e_gnt;
    @(posedge clk);
    if (vld) begin
      if (q.size() > 0) void'(q.pop_front());
      else m_unexp = 1'b1;
    end
    if (e_req && gnt) begin
      q.push_back(host_id_t'(win));
      m_ptr = (win + 1) % NH;
      m_locked = 1'b0;
    end else if (e_req) begin
      m_locked = 1'b1;
      m_lock_id = win;
    end else if (m_locked && !req[m_lock_id]) begin
      m_locked = 1'b0;
    end
    #1;
    chk("rr_ptr", dut.r_rr_ptr, m_ptr);
    chk("fifo_count", fifo_count(), q.size());
    chk("lock", dut.r_state == ArbLocked, m_locked);
  endtask

  task automatic do_reset();
    bus.h_req_i = '0;
    bus.gnt_i   = 1'b0;
    bus.valid_i = 1'b0;
    bus.rdata_i = '0;
    bus.err_i   = 1'b0;
    rst_ni = 1'b0;
    #2;
    chk("rst_req_o", bus.req_o, 1'b0);
    chk("rst_h_gnt_o", bus.h_gnt_o, 2'b00);
    chk("rst_h_valid_o", bus.h_valid_o, 2'b00);
    chk("rst_unexp", unexp, 1'b0);
    chk("rst_rr_ptr", dut.r_rr_ptr, 0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    mdl_reset();
  endtask

  logic [NH-1:0] s_req;
  logic [NH-1:0] exp_gnt_order[4];
  logic [NH-1:0] exp_vld_order[4];
  int            ngnt;
  bit            g_r;
  bit            v_r;

  initial begin
    a_addr[0] = 32'h1000_0004; a_wdata[0] = 32'h1111_1111; a_we[0] = 1'b0; a_be[0] = 4'hF;
    a_addr[1] = 32'h2000_0008; a_wdata[1] = 32'h2222_2222; a_we[1] = 1'b1; a_be[1] = 4'h3;
    drive_fields();
    mdl_reset();
    @(posedge clk);
    #1;
    do_reset();

    // single host read with a delayed grant
    ngnt = 0;
    for (int c = 0; c < 3; c++) begin
      step(2'b01, 1'b0, 1'b0, '0);
      chk("single_addr_stable", bus.addr_o, 32'h1000_0004);
      ngnt += int'(obs_gnt[0]);
    end
    step(2'b01, 1'b1, 1'b0, '0);
    ngnt += int'(obs_gnt[0]);
    chk("single_gnt_once", ngnt, 1);
    step(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("single_valid", obs_vld, 2'b01);

    // round-robin from a fresh pointer
    do_reset();
    exp_gnt_order = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_vld_order = '{2'b00, 2'b01, 2'b10, 2'b01};
    for (int c = 0; c < 4; c++) begin
      step(2'b11, 1'b1, c > 0, $urandom);
      chk("rr_gnt_order", obs_gnt, exp_gnt_order[c]);
      chk("rr_vld_order", obs_vld, exp_vld_order[c]);
    end
    step(2'b00, 1'b0, 1'b1, $urandom);
    chk("rr_last_vld", obs_vld, 2'b10);

    // lock: host1 waits, host0 arrives, host1 still owns the fields
    step(2'b10, 1'b0, 1'b0, '0);
    step(2'b11, 1'b0, 1'b0, '0);
    chk("lock_addr_host1", bus.addr_o, 32'h2000_0008);
    step(2'b11, 1'b1, 1'b0, '0);
    chk("lock_accept_host1", obs_gnt, 2'b10);
    step(2'b11, 1'b1, 1'b0, '0);
    chk("lock_next_host0", obs_gnt, 2'b01);

    // FIFO full, then a response frees a slot in the same cycle
    step(2'b11, 1'b1, 1'b0, '0);
    chk("full_no_req", bus.req_o, 1'b0);
    step(2'b11, 1'b1, 1'b1, 32'h0BAD_F00D);
    chk("full_req_reassert", bus.req_o, 1'b1);
    chk("full_pushpop_count", fifo_count(), 2'd2);
    step(2'b00, 1'b0, 1'b1, $urandom);
    step(2'b00, 1'b0, 1'b1, $urandom);

    // response with nothing outstanding
    step(2'b00, 1'b0, 1'b1, 32'h1234_5678);
    chk("unexp_no_valid", obs_vld, 2'b00);
    chk("unexp_set", unexp, 1'b1);
    step(2'b00, 1'b0, 1'b0, '0);
    chk("unexp_sticky", unexp, 1'b1);

    // random traffic with occasional protocol violations
    s_req = '0;
    for (int n = 0; n < 400; n++) begin
      g_r = ($urandom_range(0, 9) < 7);
      v_r = ($urandom_range(0, 9) < 4);
      step(s_req, g_r, v_r, $urandom);
      for (int h = 0; h < NH; h++) begin
        if (!s_req[h] || last_gnt[h]) begin
          s_req[h]   = 1'($urandom_range(0, 1));
          a_addr[h]  = $urandom;
          a_wdata[h] = $urandom;
          a_we[h]    = 1'($urandom_range(0, 1));
          a_be[h]    = 4'($urandom);
        end else if ($urandom_range(0, 19) == 0) begin
          s_req[h] = 1'b0;
        end
      end
    end

    // async reset while locked with a response pending
    a_addr[0] = 32'h1000_0004;
    for (int c = 0; c < 4 && q.size() > 0; c++) step(2'b00, 1'b0, 1'b1, $urandom);
    step(2'b01, 1'b1, 1'b0, '0);
    step(2'b01, 1'b0, 1'b0, '0);
    chk("pre_rst_ptr", dut.r_rr_ptr, 1);
    chk("pre_rst_lock", dut.r_state == ArbLocked, 1'b1);
    bus.gnt_i   = 1'b1;
    bus.valid_i = 1'b1;
    bus.rdata_i = '0;
    bus.err_i   = 1'b0;
    #1;
    rst_ni = 1'b0;
    #1;
    chk("arst_req_o", bus.req_o, 1'b0);
    chk("arst_h_gnt_o", bus.h_gnt_o, 2'b00);
    chk("arst_h_valid_o", bus.h_valid_o, 2'b00);
    chk("arst_unexp", unexp, 1'b0);
    chk("arst_rr_ptr", dut.r_rr_ptr, 0);
    chk("arst_lock", dut.r_state == ArbLocked, 1'b0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    mdl_reset();
    step(2'b10, 1'b1, 1'b0, '0);
    chk("post_rst_gnt", obs_gnt, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
